// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage running word/byte loads and stores over a req/ack port into MEM/WB
module mem_access_stage #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWrite,
  input  logic        R15Write,
  input  logic        MemtoReg,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic        sByte,
  input  logic        loadByte,
  input  logic [15:0] res_IN,
  input  logic [15:0] R15_IN,
  input  logic [15:0] op1_data_IN,
  input  logic [3:0]  regDes_IN,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        regWriteOUT,
  output logic        R15WriteOUT,
  output logic        MemtoRegOUT,
  output logic [15:0] res_OUT,
  output logic [15:0] R15_OUT,
  output logic [15:0] mem_data_OUT,
  output logic [3:0]  regDes_OUT,
  output logic        mem_err
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic mem_op, byte_op, misaligned, expire, capture;
  logic [7:0] lane;
  logic [15:0] rdata_fmt;
  always_comb begin
    mem_op = memRead | memWrite;
    byte_op = memWrite ? sByte : loadByte;
    misaligned = mem_op & ~byte_op & res_IN[0];
    expire = cnt == CNT_W'(TIMEOUT_CYC - 1);
    capture = state == S_IDLE ? ~mem_op : (dmem_ack | expire);
    stall = rst & (state == S_IDLE ? mem_op & ~misaligned : ~(dmem_ack | expire));
    lane = dmem_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    // the latched byte enables tell a byte access from a word access on completion
    rdata_fmt = dmem_we ? 16'h0 : dmem_be == 2'b11 ? dmem_rdata : {{8{lane[7]}}, lane};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= 16'h0;
      dmem_wdata <= 16'h0;
      dmem_be <= 2'b00;
      regWriteOUT <= 1'b0;
      R15WriteOUT <= 1'b0;
      MemtoRegOUT <= 1'b0;
      res_OUT <= 16'h0;
      R15_OUT <= 16'h0;
      mem_data_OUT <= 16'h0;
      regDes_OUT <= 4'h0;
      mem_err <= 1'b0;
    end else begin
      regWriteOUT <= capture & regWrite;
      R15WriteOUT <= capture & R15Write;
      MemtoRegOUT <= capture & MemtoReg & (state == S_IDLE | dmem_ack);
      mem_err <= state == S_IDLE ? misaligned : expire & ~dmem_ack;
      if (capture) begin
        res_OUT <= res_IN;
        R15_OUT <= R15_IN;
        regDes_OUT <= regDes_IN;
        mem_data_OUT <= state == S_WAIT & dmem_ack ? rdata_fmt : 16'h0;
      end
      if (state == S_IDLE) begin
        if (mem_op & ~misaligned) begin
          state <= S_WAIT;
          cnt <= '0;
          dmem_req <= 1'b1;
          dmem_we <= memWrite;
          dmem_addr <= res_IN;
          dmem_wdata <= byte_op ? {2{op1_data_IN[7:0]}} : op1_data_IN;
          dmem_be <= byte_op ? (res_IN[0] ? 2'b10 : 2'b01) : 2'b11;
        end
      end else if (dmem_ack | expire) begin
        state <= S_IDLE;
        dmem_req <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of the MEM stage handshake, formatting, alignment and timeout
module tb_mem_access_stage;
  logic clk = 1'b0, rst;
  logic regWrite, R15Write, MemtoReg, memWrite, memRead, sByte, loadByte;
  logic [15:0] res_IN, R15_IN, op1_data_IN, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] regDes_IN, regDes_OUT;
  logic stall, dmem_req, dmem_we, dmem_ack, regWriteOUT, R15WriteOUT, MemtoRegOUT, mem_err;
  logic [1:0] dmem_be;
  logic [15:0] res_OUT, R15_OUT, mem_data_OUT;
  int total = 0, bad = 0, stalls, wbs;
  always #5 clk = ~clk;
  mem_access_stage dut (
    .clk(clk), .rst(rst), .regWrite(regWrite), .R15Write(R15Write), .MemtoReg(MemtoReg),
    .memWrite(memWrite), .memRead(memRead), .sByte(sByte), .loadByte(loadByte),
    .res_IN(res_IN), .R15_IN(R15_IN), .op1_data_IN(op1_data_IN), .regDes_IN(regDes_IN),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .regWriteOUT(regWriteOUT), .R15WriteOUT(R15WriteOUT), .MemtoRegOUT(MemtoRegOUT),
    .res_OUT(res_OUT), .R15_OUT(R15_OUT), .mem_data_OUT(mem_data_OUT),
    .regDes_OUT(regDes_OUT), .mem_err(mem_err)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0; regWrite = 0; R15Write = 0; MemtoReg = 0; memWrite = 0; memRead = 1;
    sByte = 0; loadByte = 0; res_IN = 0; R15_IN = 0; op1_data_IN = 0; regDes_IN = 0;
    dmem_ack = 0; dmem_rdata = 0;
    tick(); tick();
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_regwr", regWriteOUT, 0);
    chk("rst_res", res_OUT, 0);
    chk("rst_memdata", mem_data_OUT, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    rst = 1; memRead = 0; regWrite = 1; res_IN = 16'h0010; regDes_IN = 4'h2; R15_IN = 16'h0777;
    #1 chk("alu_stall", stall, 0);
    tick();
    chk("alu_regwr", regWriteOUT, 1);
    chk("alu_res", res_OUT, 16'h0010);
    chk("alu_des", regDes_OUT, 4'h2);
    chk("alu_r15", R15_OUT, 16'h0777);
    memRead = 1; loadByte = 1; MemtoReg = 1; res_IN = 16'h0011; regDes_IN = 4'h5; dmem_rdata = 16'h80FF;
    stalls = 0; wbs = 0;
    for (int i = 0; i < 5; i++) begin
      dmem_ack = (i == 4);
      #1 stalls += int'(stall);
      tick();
      wbs += int'(regWriteOUT);
      if (i == 0) begin
        chk("lb_req", dmem_req, 1);
        chk("lb_be", dmem_be, 2'b10);
        chk("lb_we", dmem_we, 0);
        chk("lb_addr", dmem_addr, 16'h0011);
        chk("lb_bubble", regWriteOUT, 0);
      end
    end
    memRead = 0; loadByte = 0; regWrite = 0; MemtoReg = 0; dmem_ack = 0;
    chk("lb_data", mem_data_OUT, 16'hFF80);
    chk("lb_m2r", MemtoRegOUT, 1);
    chk("lb_des", regDes_OUT, 4'h5);
    chk("lb_req_drop", dmem_req, 0);
    chk("lb_stalls", 16'(stalls), 4);
    chk("lb_wbs", 16'(wbs), 1);
    memWrite = 1; sByte = 1; res_IN = 16'h0020; op1_data_IN = 16'h12AB;
    #1 chk("sb_stall", stall, 1);
    tick();
    chk("sb_wdata", dmem_wdata, 16'hABAB);
    chk("sb_be", dmem_be, 2'b01);
    chk("sb_we", dmem_we, 1);
    dmem_ack = 1;
    #1 chk("sb_ack_stall", stall, 0);
    tick();
    chk("sb_done_req", dmem_req, 0);
    chk("sb_memdata", mem_data_OUT, 0);
    memRead = 1; sByte = 0; loadByte = 1; res_IN = 16'h0030; op1_data_IN = 16'hBEEF; dmem_ack = 0;
    tick();
    chk("rw_we", dmem_we, 1);
    chk("rw_be", dmem_be, 2'b11);
    chk("rw_wdata", dmem_wdata, 16'hBEEF);
    dmem_ack = 1; tick();
    memWrite = 0; loadByte = 0; res_IN = 16'h0021; regWrite = 1; dmem_ack = 0;
    #1 chk("mis_stall", stall, 0);
    tick();
    chk("mis_err", mem_err, 1);
    chk("mis_req", dmem_req, 0);
    chk("mis_regwr", regWriteOUT, 0);
    memRead = 0; regWrite = 0;
    tick();
    chk("mis_err_pulse", mem_err, 0);
    chk("mis_req2", dmem_req, 0);
    memRead = 1; res_IN = 16'h0040; MemtoReg = 1; regWrite = 1; dmem_rdata = 16'h5555;
    tick();
    stalls = 0;
    for (int k = 0; k < 14; k++) begin
      stalls += int'(stall);
      tick();
    end
    chk("to_stalls", 16'(stalls), 14);
    chk("to_last_stall", stall, 0);
    chk("to_pre_err", mem_err, 0);
    tick();
    chk("to_err", mem_err, 1);
    chk("to_req", dmem_req, 0);
    chk("to_data", mem_data_OUT, 0);
    chk("to_m2r", MemtoRegOUT, 0);
    chk("to_regwr", regWriteOUT, 1);
    chk("to_res", res_OUT, 16'h0040);
    res_IN = 16'h0060; dmem_rdata = 16'h1234;
    tick();
    for (int k = 0; k < 14; k++) tick();
    dmem_ack = 1;
    #1 chk("ackto_stall", stall, 0);
    tick();
    chk("ackto_err", mem_err, 0);
    chk("ackto_data", mem_data_OUT, 16'h1234);
    chk("ackto_m2r", MemtoRegOUT, 1);
    dmem_ack = 0; res_IN = 16'h0050;
    tick(); tick(); tick();
    chk("rw_mid_req", dmem_req, 1);
    rst = 0;
    tick();
    chk("rstw_req", dmem_req, 0);
    chk("rstw_stall", stall, 0);
    chk("rstw_regwr", regWriteOUT, 0);
    rst = 1; memRead = 0; MemtoReg = 0; dmem_ack = 1;
    tick();
    chk("rstw_idle_req", dmem_req, 0);
    chk("rstw_idle_regwr", regWriteOUT, 1);
    chk("rstw_idle_data", mem_data_OUT, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
